ddr_tx_lane_ctrl: RTL and testbench

Parametrised multi-lane transmit controller for O_DDR / O_BUFT_DS output paths. Buffers 2-bit-per-lane words in a small FIFO and sequences tristate enable, optional preamble, data burst, idle hold and turn-off. Drives the D/E inputs of CHANNELS O_DDR primitives and the T input of the matching tristate output buffers. Sits between fabric logic and the I/O primitives, in the `clk` domain behind the clock I_BUF.

---
 rtl/ddr_tx_lane_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ddr_tx_lane_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ddr_tx_lane_ctrl.sv
// Multi-lane DDR transmit controller: word FIFO plus enable/preamble/send/hold/off sequencing for O_DDR and O_BUFT_DS.
// Optional preamble phase is compiled in with `define DDR_TX_PREAMBLE_EN.
module ddr_tx_lane_ctrl #(
   parameter int CHANNELS        = 2,
   parameter int DEPTH           = 8,
   parameter int HOLD_CYCLES     = 4,
   parameter int PREAMBLE_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic [2*CHANNELS-1:0]     in_data,
   output logic                      in_ready,
   output logic [2*CHANNELS-1:0]     ddr_d,
   output logic                      ddr_e,
   output logic                      buf_t,
   output logic                      busy,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [15:0]               word_cnt
);

   localparam int W  = 2 * CHANNELS;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] FULL     = CW'(DEPTH);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || HOLD_CYCLES < 1 || PREAMBLE_CYCLES < 1) begin : gBadParam
      $error("ddr_tx_lane_ctrl: illegal parameter value");
   end

`ifdef DDR_TX_PREAMBLE_EN
   localparam int PW = $clog2(PREAMBLE_CYCLES + 1);
   localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ENABLE   = 3'd1,
      PREAMBLE = 3'd2,
      SEND     = 3'd3,
      HOLD     = 3'd4,
      OFF      = 3'd5
   } state_t;

   logic [PW-1:0] preCnt_q, preCnt_d;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENABLE = 3'd1,
      SEND   = 3'd3,
      HOLD   = 3'd4,
      OFF    = 3'd5
   } state_t;
`endif

   state_t         state_q, state_d;
   logic [W-1:0]   mem [DEPTH];
   logic [AW-1:0]  wrPtr_q, rdPtr_q;
   logic [CW-1:0]  count_q, count_d;
   logic [HW-1:0]  hold_q, hold_d;
   logic [W-1:0]   ddrD_q, ddrD_d;
   logic [15:0]    wordCnt_q, wordCnt_d;
   logic           bufT_q, ddrE_q;
   logic           push, pop;

   // Full-ness comes from the registered count, so a pop cannot make room for a push in the same cycle.
   always_comb begin
      push    = in_valid && (count_q != FULL);
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem[wrPtr_q] <= in_data;
      end
   end

   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      ddrD_d    = '0;
      wordCnt_d = wordCnt_q;
      pop       = 1'b0;
`ifdef DDR_TX_PREAMBLE_EN
      preCnt_d  = preCnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               state_d = ENABLE;
            end
         end
         ENABLE: begin
            hold_d = '0;
`ifdef DDR_TX_PREAMBLE_EN
            preCnt_d = '0;
            state_d  = PREAMBLE;
`else
            state_d  = SEND;
`endif
         end
`ifdef DDR_TX_PREAMBLE_EN
         PREAMBLE: begin
            ddrD_d = {CHANNELS{2'b10}};
            if (preCnt_q == PRE_LAST) begin
               state_d = SEND;
            end else begin
               preCnt_d = preCnt_q + PW'(1);
            end
         end
`endif
         SEND, HOLD: begin
            // Any queued word restarts the burst; otherwise count idle cycles until the pad may be released.
            if (count_q != '0) begin
               ddrD_d    = mem[rdPtr_q];
               pop       = 1'b1;
               wordCnt_d = wordCnt_q + 16'd1;
               hold_d    = '0;
               state_d   = SEND;
            end else if (hold_q == HOLD_MAX) begin
               state_d = OFF;
            end else begin
               hold_d  = hold_q + HW'(1);
               state_d = HOLD;
            end
         end
         OFF: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Pad controls are registered from the next state so they always match the state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         hold_q    <= '0;
         ddrD_q    <= '0;
         wordCnt_q <= '0;
         bufT_q    <= 1'b0;
         ddrE_q    <= 1'b0;
`ifdef DDR_TX_PREAMBLE_EN
         preCnt_q  <= '0;
`endif
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         hold_q    <= hold_d;
         ddrD_q    <= ddrD_d;
         wordCnt_q <= wordCnt_d;
         bufT_q    <= (state_d != IDLE);
         ddrE_q    <= (state_d != IDLE) && (state_d != OFF);
`ifdef DDR_TX_PREAMBLE_EN
         preCnt_q  <= preCnt_d;
`endif
         if (push) begin
            wrPtr_q <= wrPtr_q + AW'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + AW'(1);
         end
      end
   end

   assign in_ready   = (count_q != FULL);
   assign ddr_d      = ddrD_q;
   assign ddr_e      = ddrE_q;
   assign buf_t      = bufT_q;
   assign busy       = bufT_q;
   assign fifo_count = count_q;
   assign word_cnt   = wordCnt_q;

endmodule

// File: tb/tb_ddr_tx_lane_ctrl.sv
// Directed bench for ddr_tx_lane_ctrl: main instance (DEPTH=8) plus a DEPTH=2 instance for full/drop behaviour.
module tb_ddr_tx_lane_ctrl;

   localparam int H = 4;
`ifdef DDR_TX_PREAMBLE_EN
   localparam int PRE = 2;
   localparam logic [3:0] FIRST = 4'h5;
`else
   localparam int PRE = 0;
   localparam logic [3:0] FIRST = 4'hA;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       inValid = 1'b0;
   logic       inValid2 = 1'b0;
   logic [3:0] inData = '0;
   logic [3:0] inData2 = '0;

   logic        inReady, ddrE, bufT, busy;
   logic [3:0]  ddrD;
   logic [3:0]  fifoCount;
   logic [15:0] wordCnt;

   logic        inReady2, ddrE2, bufT2, busy2;
   logic [3:0]  ddrD2;
   logic [1:0]  fifoCount2;
   logic [15:0] wordCnt2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   ddr_tx_lane_ctrl #(
      .CHANNELS(2), .DEPTH(8), .HOLD_CYCLES(H), .PREAMBLE_CYCLES(2)
   ) uDut (
      .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .in_ready(inReady),
      .ddr_d(ddrD), .ddr_e(ddrE), .buf_t(bufT), .busy(busy),
      .fifo_count(fifoCount), .word_cnt(wordCnt)
   );

   ddr_tx_lane_ctrl #(
      .CHANNELS(2), .DEPTH(2), .HOLD_CYCLES(H), .PREAMBLE_CYCLES(2)
   ) uDut2 (
      .clk(clk), .rst(rst), .in_valid(inValid2), .in_data(inData2), .in_ready(inReady2),
      .ddr_d(ddrD2), .ddr_e(ddrE2), .buf_t(bufT2), .busy(busy2),
      .fifo_count(fifoCount2), .word_cnt(wordCnt2)
   );

   task automatic applyStimulus(input logic v, input logic [3:0] d, input logic v2, input logic [3:0] d2);
      inValid  = v;
      inData   = d;
      inValid2 = v2;
      inData2  = d2;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset and idle
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
      applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
      checkOutput("rst_buft", 32'(bufT), 32'd0);
      checkOutput("rst_ddre", 32'(ddrE), 32'd0);
      checkOutput("rst_ddrd", 32'(ddrD), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_ready", 32'(inReady), 32'd1);
      checkOutput("rst_count", 32'(fifoCount), 32'd0);
      checkOutput("rst_wcnt", 32'(wordCnt), 32'd0);
      rst = 1'b0;
      repeat (10) applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
      checkOutput("idle_buft", 32'(bufT), 32'd0);
      checkOutput("idle_ddre", 32'(ddrE), 32'd0);
      checkOutput("idle_ddrd", 32'(ddrD), 32'd0);
      checkOutput("idle_ready", 32'(inReady), 32'd1);
      checkOutput("idle_count", 32'(fifoCount), 32'd0);

      // Single word: latency, hold, OFF and pad release
      for (int e = 0; e <= H + 6 + PRE; e++) begin
         applyStimulus(e == 0, FIRST, 1'b0, 4'h0);
         if (e == 0) checkOutput("one_count", 32'(fifoCount), 32'd1);
         if (e == 1) checkOutput("one_en_buft", 32'(bufT), 32'd1);
         if (e == 1) checkOutput("one_en_ddre", 32'(ddrE), 32'd1);
         if (e == 2) checkOutput("one_en_ddrd", 32'(ddrD), 32'd0);
`ifdef DDR_TX_PREAMBLE_EN
         if (e == 3 || e == 4) checkOutput("one_preamble", 32'(ddrD), 32'hA);
`endif
         if (e == 3 + PRE) checkOutput("one_data", 32'(ddrD), 32'(FIRST));
         if (e == 4 + PRE) checkOutput("one_after", 32'(ddrD), 32'd0);
         if (e == 4 + PRE) checkOutput("one_hold_buft", 32'(bufT), 32'd1);
         if (e == 3 + PRE + H) checkOutput("one_lasthold_ddre", 32'(ddrE), 32'd1);
         if (e == 4 + PRE + H) checkOutput("one_off_ddre", 32'(ddrE), 32'd0);
         if (e == 4 + PRE + H) checkOutput("one_off_buft", 32'(bufT), 32'd1);
         if (e == 5 + PRE + H) checkOutput("one_rel_buft", 32'(bufT), 32'd0);
         if (e == 5 + PRE + H) checkOutput("one_rel_busy", 32'(busy), 32'd0);
      end
      checkOutput("one_wcnt", 32'(wordCnt), 32'd1);

      // Streaming 8 words back to back
      for (int e = 0; e < 20; e++) begin
         applyStimulus(e < 8, 4'(e + 1), 1'b0, 4'h0);
         if (e >= 3 + PRE && e <= 10 + PRE) checkOutput("stream_data", 32'(ddrD), 32'(e - 2 - PRE));
         if (e < 8) checkOutput("stream_ready", 32'(inReady), 32'd1);
         if (e == 6) checkOutput("stream_count", 32'(fifoCount), 32'(3 + PRE));
         if (e == 11 + PRE) checkOutput("stream_end", 32'(ddrD), 32'd0);
      end
      checkOutput("stream_busy", 32'(busy), 32'd0);
      checkOutput("stream_wcnt", 32'(wordCnt), 32'd9);

      // Late word inside the hold window keeps the burst alive
      for (int e = 0; e < 20; e++) begin
         applyStimulus((e < 3) || (e == 7 + PRE), (e < 3) ? 4'(11 + e) : 4'hE, 1'b0, 4'h0);
         if (e >= 1 && e <= 9 + PRE + H) checkOutput("late_buft", 32'(bufT), 32'd1);
         if (e >= 3 + PRE && e <= 5 + PRE) checkOutput("late_data", 32'(ddrD), 32'(8 + e - PRE));
         if (e == 6 + PRE || e == 7 + PRE) checkOutput("late_gap", 32'(ddrD), 32'd0);
         if (e == 7 + PRE) checkOutput("late_gap_ddre", 32'(ddrE), 32'd1);
         if (e == 8 + PRE) checkOutput("late_word", 32'(ddrD), 32'hE);
         if (e == 10 + PRE + H) checkOutput("late_rel_buft", 32'(bufT), 32'd0);
      end
      checkOutput("late_wcnt", 32'(wordCnt), 32'd13);
      checkOutput("late_count", 32'(fifoCount), 32'd0);

      // Full FIFO on the DEPTH=2 instance: extra pushes dropped, pop while full gives no push
      for (int e = 0; e < 10 + PRE; e++) begin
         applyStimulus(1'b0, 4'h0, e <= 3 + PRE, 4'(e + 1));
         if (e == 0) checkOutput("full_count0", 32'(fifoCount2), 32'd1);
         if (e == 0) checkOutput("full_ready0", 32'(inReady2), 32'd1);
         if (e == 1) checkOutput("full_count1", 32'(fifoCount2), 32'd2);
         if (e == 1) checkOutput("full_ready1", 32'(inReady2), 32'd0);
         if (e == 2) checkOutput("full_drop", 32'(fifoCount2), 32'd2);
         if (e == 3 + PRE) checkOutput("full_poponly", 32'(fifoCount2), 32'd1);
         if (e == 3 + PRE) checkOutput("full_data1", 32'(ddrD2), 32'd1);
         if (e == 4 + PRE) checkOutput("full_data2", 32'(ddrD2), 32'd2);
         if (e == 4 + PRE) checkOutput("full_empty", 32'(fifoCount2), 32'd0);
         if (e == 4 + PRE) checkOutput("full_ready", 32'(inReady2), 32'd1);
         if (e == 5 + PRE) checkOutput("full_after", 32'(ddrD2), 32'd0);
      end
      checkOutput("full_wcnt", 32'(wordCnt2), 32'd2);

      // Reset in the middle of a burst, then restart
      for (int e = 0; e < 5; e++) begin
         applyStimulus(1'b1, 4'(9 + e), 1'b0, 4'h0);
      end
      checkOutput("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b1, 4'hF, 1'b0, 4'h0);
      checkOutput("mid_rst_ddrd", 32'(ddrD), 32'd0);
      checkOutput("mid_rst_ddre", 32'(ddrE), 32'd0);
      checkOutput("mid_rst_buft", 32'(bufT), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_ready", 32'(inReady), 32'd1);
      checkOutput("mid_rst_count", 32'(fifoCount), 32'd0);
      checkOutput("mid_rst_wcnt", 32'(wordCnt), 32'd0);
      rst = 1'b0;
      repeat (3) applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
      checkOutput("mid_quiet_busy", 32'(busy), 32'd0);
      checkOutput("mid_quiet_count", 32'(fifoCount), 32'd0);
      for (int e = 0; e < 6 + PRE; e++) begin
         applyStimulus(e == 0, 4'h7, 1'b0, 4'h0);
         if (e == 0) checkOutput("re_count", 32'(fifoCount), 32'd1);
         if (e == 1) checkOutput("re_buft", 32'(bufT), 32'd1);
         if (e == 2) checkOutput("re_ddrd0", 32'(ddrD), 32'd0);
         if (e == 3 + PRE) checkOutput("re_data", 32'(ddrD), 32'h7);
         if (e == 3 + PRE) checkOutput("re_wcnt", 32'(wordCnt), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
